// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared time types, BCD digit limits and load validation
package rtc_pkg;

  localparam int DEFAULT_CLK_DIV = 50000000;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] TENS_MAX    = 4'd5;
  localparam logic [3:0] HOUR_T_MAX  = 4'd2;
  localparam logic [3:0] HOUR_U_LAST = 4'd3;

  typedef struct packed {
    logic [3:0] hh_t;
    logic [3:0] hh_u;
    logic [3:0] mm_t;
    logic [3:0] mm_u;
    logic [3:0] ss_t;
    logic [3:0] ss_u;
  } time_t;

  // A 24-hour BCD time is legal when every digit is a decimal digit,
  // the tens of minutes/seconds stay within 0..5 and the hour is 00..23.
  function automatic logic time_valid(input time_t t);
    return (t.hh_t <= HOUR_T_MAX) && (t.hh_u <= DIGIT_MAX) &&
           !((t.hh_t == HOUR_T_MAX) && (t.hh_u > HOUR_U_LAST)) &&
           (t.mm_t <= TENS_MAX) && (t.mm_u <= DIGIT_MAX) &&
           (t.ss_t <= TENS_MAX) && (t.ss_u <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - one BCD digit counter with load, dynamic wrap value and carry
module bcd_digit_cnt
  import rtc_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] wrap_val,
  output logic [3:0] q,
  output logic [3:0] nxt,
  output logic       carry
);

  // The last value before wrapping; the hour-units digit narrows it to 3
  // while the tens is 2, every other digit wraps at its static MAX.
  logic [3:0] last;
  assign last  = (wrap_val > MAX) ? MAX : wrap_val;
  assign carry = inc && !load && (q == last);

  // Next digit value: load has priority over counting.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = load_val;
    end else if (inc) begin
      nxt = carry ? 4'd0 : q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 4'd0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bcd_rtc_core.sv
// rtl/bcd_rtc_core.sv - BCD real-time clock with prescaler, validated load, 12/24h display and alarm
module bcd_rtc_core
  import rtc_pkg::*;
#(
  parameter int CLK_DIV  = DEFAULT_CLK_DIV,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        mode_12h,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [23:0] set_time,
  input  logic [23:0] alarm_time,
  input  logic        alarm_on,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        alarm_hit,
  output logic        set_err
);

  localparam int            PW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  time_t         cur, nxt, ld;
  logic [PW-1:0] presc;
  logic          tick, accept, load_ok, load_bad, adv;
  logic          c_ss_u, c_ss_t, c_mm_u, c_mm_t, c_hh_u, c_hh_t;
  logic [3:0]    hh_u_wrap;

  assign ld       = time_t'(set_time);
  assign tick     = run_en && (presc == PRESC_LAST);
  assign accept   = set_valid && set_ready;
  assign load_ok  = accept && time_valid(ld);
  assign load_bad = accept && !load_ok;
  // A valid load in the tick cycle swallows that tick.
  assign adv      = tick && !load_ok;

  assign hh_u_wrap = (cur.hh_t == HOUR_T_MAX) ? HOUR_U_LAST : DIGIT_MAX;

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_ss_u (.clk(clk), .rst(rst), .inc(adv), .load(load_ok),
    .load_val(ld.ss_u), .wrap_val(DIGIT_MAX), .q(cur.ss_u), .nxt(nxt.ss_u), .carry(c_ss_u));
  bcd_digit_cnt #(.MAX(TENS_MAX)) u_ss_t (.clk(clk), .rst(rst), .inc(c_ss_u), .load(load_ok),
    .load_val(ld.ss_t), .wrap_val(TENS_MAX), .q(cur.ss_t), .nxt(nxt.ss_t), .carry(c_ss_t));
  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_mm_u (.clk(clk), .rst(rst), .inc(c_ss_t), .load(load_ok),
    .load_val(ld.mm_u), .wrap_val(DIGIT_MAX), .q(cur.mm_u), .nxt(nxt.mm_u), .carry(c_mm_u));
  bcd_digit_cnt #(.MAX(TENS_MAX)) u_mm_t (.clk(clk), .rst(rst), .inc(c_mm_u), .load(load_ok),
    .load_val(ld.mm_t), .wrap_val(TENS_MAX), .q(cur.mm_t), .nxt(nxt.mm_t), .carry(c_mm_t));
  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_hh_u (.clk(clk), .rst(rst), .inc(c_mm_t), .load(load_ok),
    .load_val(ld.hh_u), .wrap_val(hh_u_wrap), .q(cur.hh_u), .nxt(nxt.hh_u), .carry(c_hh_u));
  // Carry out of the hours-tens digit is exactly the 23:59:59 -> 00:00:00 wrap.
  bcd_digit_cnt #(.MAX(HOUR_T_MAX)) u_hh_t (.clk(clk), .rst(rst), .inc(c_hh_u), .load(load_ok),
    .load_val(ld.hh_t), .wrap_val(HOUR_T_MAX), .q(cur.hh_t), .nxt(nxt.hh_t), .carry(c_hh_t));

  // Prescaler, load handshake and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      if (load_ok || tick) begin
        presc <= '0;
      end else if (run_en) begin
        presc <= presc + PW'(1);
      end
      set_ready <= !accept;
      set_err   <= load_bad;
      sec_tick  <= adv;
      day_wrap  <= c_hh_t;
    end
  end

  generate
    if (ALARM_EN) begin : g_alarm
      // Compare against the value the counters are about to take, so the
      // pulse lines up with sec_tick; loads never reach here since adv=0.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          alarm_hit <= 1'b0;
        end else begin
          alarm_hit <= alarm_on && adv && (nxt == time_t'(alarm_time));
        end
      end
    end else begin : g_no_alarm
      assign alarm_hit = 1'b0;
    end
  endgenerate

  // Display decode: 24-hour state to 12-hour form when requested.
  logic [4:0] hour24, hour12;
  time_t      disp;
  assign hour24 = ({1'b0, cur.hh_t} * 5'd10) + {1'b0, cur.hh_u};

  always_comb begin
    disp   = cur;
    hour12 = hour24;
    pm     = 1'b0;
    if (mode_12h) begin
      pm = (hour24 >= 5'd12);
      if (hour24 == 5'd0) begin
        hour12 = 5'd12;
      end else if (hour24 > 5'd12) begin
        hour12 = hour24 - 5'd12;
      end
      disp.hh_t = (hour12 >= 5'd10) ? 4'd1 : 4'd0;
      disp.hh_u = (hour12 >= 5'd10) ? 4'(hour12 - 5'd10) : hour12[3:0];
    end
  end

  assign time_bcd = disp;

endmodule
